// File: rtl/ack_vector_sequencer.sv
// ack_vector_sequencer: interrupt-acknowledge data path of an 8259A-style
// controller. Counts synchronized INTA pulses (IDLE/ACK1/ACK2/ACK3), latches
// the acknowledged request at the first pulse, drives CALL / vector bytes for
// MCS-80/85 or 8086 mode, and serves OCW3 poll reads (POLL).
// Optional build macro: ACK_SEQ_SPURIOUS_EN (empty latch becomes a spurious
// acknowledge of IR index IR_COUNT-1 instead of a silent sequence).
//
// Bus handshake: out_control_logic_data qualifies control_logic_data; both are
// registered and change on the same rising edge, and control_logic_data is
// 8'h00 whenever out_control_logic_data is 0.
module ack_vector_sequencer #(
  parameter int IR_IDX_W = 3
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        interrupt_acknowledge_n,
  input  logic                        read,
  input  logic                        poll_command,
  input  logic                        cascade_slave,
  input  logic                        cascade_output_ack_2_3,
  input  logic                        u8086_or_mcs80_config,
  input  logic                        call_address_interval_4_or_8_config,
  input  logic [10:0]                 interrupt_vector_address,
  input  logic [(2**IR_IDX_W)-1:0]    highest_request,
  output logic                        out_control_logic_data,
  output logic [7:0]                  control_logic_data,
  output logic [(2**IR_IDX_W)-1:0]    acknowledge_interrupt,
  output logic                        isr_set,
  output logic                        end_of_acknowledge,
  output logic                        spurious,
  output logic [2:0]                  o_dbg_state
);

  localparam int IR_COUNT = 2**IR_IDX_W;
  localparam logic [7:0] IDX_MASK = 8'((1 << IR_IDX_W) - 1);
  localparam logic [7:0] CALL_OPCODE = 8'hCD;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ACK1 = 3'd1,
    S_ACK2 = 3'd2,
    S_ACK3 = 3'd3,
    S_POLL = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_inta_s1;
  logic                  r_inta_s2;
  logic                  r_inta_d;
  logic                  r_read_d;
  logic                  r_mode_8086;
  logic                  r_interval8;
  logic [IR_COUNT-1:0]   r_ack;
  logic                  r_isr_set;
  logic                  r_eoa;
  logic                  r_drive;
  logic [7:0]            r_data;

  logic                  w_fall;
  logic                  w_rise;
  logic                  w_inta_low;
  logic                  w_read_fall;
  logic [IR_IDX_W-1:0]   w_idx;
  logic [7:0]            w_idx8;
  logic                  w_present;
  logic [7:0]            w_vec_byte;
  logic [7:0]            w_poll_byte;
  logic [IR_COUNT-1:0]   w_latch_req;

  // Binary index of a one-hot request vector (0 when empty).
  function automatic logic [IR_IDX_W-1:0] f_encode(input logic [IR_COUNT-1:0] v);
    logic [IR_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < IR_COUNT; i++) begin
      if (v[i]) idx = idx | i[IR_IDX_W-1:0];
    end
    return idx;
  endfunction

  assign w_fall      = r_inta_d & ~r_inta_s2;
  assign w_rise      = ~r_inta_d & r_inta_s2;
  assign w_inta_low  = ~r_inta_s2;
  assign w_read_fall = r_read_d & ~read;

  assign w_idx       = f_encode(r_ack);
  assign w_idx8      = {{(8-IR_IDX_W){1'b0}}, w_idx};
  assign w_present   = |r_ack;
  assign w_poll_byte = {w_present, 7'b0} | w_idx8;

`ifdef ACK_SEQ_SPURIOUS_EN
  logic w_req_empty;
  logic r_spurious;
  assign w_req_empty = ~|highest_request;
  // An empty request at the first pulse is acknowledged as the lowest-priority line.
  assign w_latch_req = w_req_empty ? {1'b1, {(IR_COUNT-1){1'b0}}} : highest_request;
  assign spurious    = r_spurious;

  // Spurious flag: set with the ACK1 latch, held until end_of_acknowledge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_spurious <= 1'b0;
    end else if (r_state == S_IDLE && w_fall) begin
      r_spurious <= w_req_empty;
    end else if (r_eoa) begin
      r_spurious <= 1'b0;
    end
  end
`else
  assign w_latch_req = highest_request;
  assign spurious    = 1'b0;
`endif

  // Vector byte for ACK2 from the latched request and latched mode bits.
  always_comb begin
    w_vec_byte = 8'h00;
    if (r_mode_8086) begin
      w_vec_byte = (interrupt_vector_address[10:3] & ~IDX_MASK) | w_idx8;
    end else if (r_interval8) begin
      w_vec_byte = ({interrupt_vector_address[2:0], 5'b0} & ~(IDX_MASK << 3)) | (w_idx8 << 3);
    end else begin
      w_vec_byte = ({interrupt_vector_address[2:0], 5'b0} & ~(IDX_MASK << 2)) | (w_idx8 << 2);
    end
  end

  // INTA two-flop synchronizer plus edge-detect history; read history for poll.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_inta_s1 <= 1'b1;
      r_inta_s2 <= 1'b1;
      r_inta_d  <= 1'b1;
      r_read_d  <= 1'b0;
    end else begin
      r_inta_s1 <= interrupt_acknowledge_n;
      r_inta_s2 <= r_inta_s1;
      r_inta_d  <= r_inta_s2;
      r_read_d  <= read;
    end
  end

  // Sequencer FSM with registered bus drive and one-clock status pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_mode_8086 <= 1'b0;
      r_interval8 <= 1'b0;
      r_ack       <= '0;
      r_isr_set   <= 1'b0;
      r_eoa       <= 1'b0;
      r_drive     <= 1'b0;
      r_data      <= 8'h00;
    end else begin
      r_isr_set <= 1'b0;
      r_eoa     <= 1'b0;
      r_drive   <= 1'b0;
      r_data    <= 8'h00;
      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            // INTA wins over a simultaneous poll_command.
            r_ack       <= w_latch_req;
            r_mode_8086 <= u8086_or_mcs80_config;
            r_interval8 <= call_address_interval_4_or_8_config;
            r_isr_set   <= |highest_request;
            r_state     <= S_ACK1;
            // Mode bits are not latched yet, so ACK1 drive uses the live inputs.
            if (!cascade_slave && !u8086_or_mcs80_config) begin
              r_drive <= 1'b1;
              r_data  <= CALL_OPCODE;
            end
          end else if (poll_command) begin
            r_ack   <= highest_request;
            r_state <= S_POLL;
          end
        end
        S_ACK1: begin
          if (w_rise) begin
            r_state <= S_ACK2;
          end else if (w_inta_low && !cascade_slave && !r_mode_8086) begin
            r_drive <= 1'b1;
            r_data  <= CALL_OPCODE;
          end
        end
        S_ACK2: begin
          if (w_rise) begin
            if (r_mode_8086) begin
              r_eoa   <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ACK3;
            end
          end else if (w_inta_low && cascade_output_ack_2_3 && w_present) begin
            r_drive <= 1'b1;
            r_data  <= w_vec_byte;
          end
        end
        S_ACK3: begin
          if (w_rise) begin
            r_eoa   <= 1'b1;
            r_state <= S_IDLE;
          end else if (w_inta_low && cascade_output_ack_2_3 && w_present) begin
            r_drive <= 1'b1;
            r_data  <= interrupt_vector_address[10:3];
          end
        end
        S_POLL: begin
          // INTA edges are ignored while a poll is pending.
          if (w_read_fall) begin
            r_eoa     <= 1'b1;
            r_isr_set <= w_present;
            r_state   <= S_IDLE;
          end else if (read) begin
            r_drive <= 1'b1;
            r_data  <= w_poll_byte;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign out_control_logic_data = r_drive;
  assign control_logic_data     = r_data;
  assign acknowledge_interrupt  = r_ack;
  assign isr_set                = r_isr_set;
  assign end_of_acknowledge     = r_eoa;
  assign o_dbg_state            = r_state;

endmodule
